// File: rtl/bk_adder_pipe_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Brent-Kung adder.
package bk_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } bk_gp_t;

    function automatic int bk_levels(input int width);
        return 2 * $clog2(width) - 1;
    endfunction

    function automatic int bk_cuts(input int width, input int cut);
        return (cut == 0) ? 0 : (bk_levels(width) + cut - 1) / cut - 1;
    endfunction

    function automatic int bk_latency(input int width, input int cut);
        return 2 + bk_cuts(width, cut);
    endfunction

    // Registers go after every cut-th level, never after the last one.
    function automatic bit bk_is_cut(input int level, input int width, input int cut);
        return (cut > 0) && (level % cut == 0) && (level < bk_levels(width));
    endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// One Brent-Kung dot operator: (g,p) o (g',p') = (g | p&g', p&p').
module bk_prefix_cell
    import bk_pkg::*;
(
    input  bk_gp_t hi,
    input  bk_gp_t lo,
    output bk_gp_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = hi.p & lo.p;

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder with valid/ready flow control and optional prefix cuts.
// Optional subtract mode (sub_in port) is enabled by defining BK_ADDER_SUB_EN.
module bk_adder_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PIPE_CUT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
`ifdef BK_ADDER_SUB_EN
    input  logic             sub_in,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NLOG = $clog2(WIDTH);
    localparam int NL   = bk_levels(WIDTH);

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
`ifdef BK_ADDER_SUB_EN
    assign b_eff = sub_in ? ~b_in : b_in;
    assign c_eff = sub_in ? 1'b1  : c_in;
`else
    assign b_eff = b_in;
    assign c_eff = c_in;
`endif

    logic [WIDTH-1:0] a_q, b_q;
    logic             c_q, v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else if (en) begin
            a_q <= a_in;
            b_q <= b_eff;
            c_q <= c_eff;
            v_q <= in_valid;
        end
    end

    // Index k of *_s is the value entering level k+1 (after any cut register).
    bk_gp_t [NL:1][WIDTH-1:0] gp_o;
    bk_gp_t [NL:0][WIDTH-1:0] gp_s;
    logic   [NL:0][WIDTH-1:0] x_s;
    logic   [NL:0]            c_s, v_s;

    logic [WIDTH-1:0] g0, p0;
    assign p0 = a_q | b_q;
    // Carry-in folds into bit 0 so every prefix G already includes it.
    assign g0 = (a_q & b_q) | {{(WIDTH-1){1'b0}}, p0[0] & c_q};

    for (genvar i = 0; i < WIDTH; i++) begin : g_lvl0
        assign gp_s[0][i] = {g0[i], p0[i]};
    end
    assign x_s[0] = a_q ^ b_q;
    assign c_s[0] = c_q;
    assign v_s[0] = v_q;

    for (genvar k = 1; k <= NL; k++) begin : g_lvl
        localparam bit UP = (k <= NLOG);
        localparam int S  = UP ? (1 << (k - 1)) : (1 << (2 * NLOG - 1 - k));

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (UP ? ((i + 1) % (2 * S) == 0)
                   : (((i + 1) % (2 * S) == S) && (i + 1 >= 3 * S))) begin : g_dot
                bk_prefix_cell u_cell (
                    .hi (gp_s[k-1][i]),
                    .lo (gp_s[k-1][i-S]),
                    .o  (gp_o[k][i])
                );
            end else begin : g_pass
                assign gp_o[k][i] = gp_s[k-1][i];
            end
        end

        if (bk_is_cut(k, WIDTH, PIPE_CUT)) begin : g_cut
            bk_gp_t [WIDTH-1:0] gp_r;
            logic   [WIDTH-1:0] x_r;
            logic               c_r, v_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    gp_r <= '0;
                    x_r  <= '0;
                    c_r  <= 1'b0;
                    v_r  <= 1'b0;
                end else if (en) begin
                    gp_r <= gp_o[k];
                    x_r  <= x_s[k-1];
                    c_r  <= c_s[k-1];
                    v_r  <= v_s[k-1];
                end
            end

            assign gp_s[k] = gp_r;
            assign x_s[k]  = x_r;
            assign c_s[k]  = c_r;
            assign v_s[k]  = v_r;
        end else begin : g_nocut
            assign gp_s[k] = gp_o[k];
            assign x_s[k]  = x_s[k-1];
            assign c_s[k]  = c_s[k-1];
            assign v_s[k]  = v_s[k-1];
        end
    end

    logic [WIDTH-1:0] g_fin, p_fin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fin_bit
        assign g_fin[i] = gp_s[NL][i].g;
        assign p_fin[i] = gp_s[NL][i].p;
    end

    // Group propagate is not needed once every carry is resolved.
    logic unused_p;
    assign unused_p = ^p_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
        end else if (en) begin
            out_valid <= v_s[NL];
            sum       <= x_s[NL] ^ {g_fin[WIDTH-2:0], c_s[NL]};
            c_out     <= g_fin[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Bench for bk_adder_pipe: 16/2, 8/2 and 64/0 instances checked against a scoreboard.
module tb_bk_adder_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv16 = 0, or16 = 1, c16 = 0, ir16, ov16, co16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    logic        iv8 = 0, or8 = 1, c8 = 0, sub8 = 0, ir8, ov8, co8;
    logic [7:0]  a8 = 0, b8 = 0, s8, nb8;
    logic        iv64 = 0, or64 = 1, c64 = 0, ir64, ov64, co64;
    logic [63:0] a64 = 0, b64 = 0, s64;

    assign nb8 = ~b8;

    bk_adder_pipe #(.WIDTH(16), .PIPE_CUT(2)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a_in(a16), .b_in(b16), .c_in(c16),
`ifdef BK_ADDER_SUB_EN
        .sub_in(1'b0),
`endif
        .out_valid(ov16), .out_ready(or16), .sum(s16), .c_out(co16));

    bk_adder_pipe #(.WIDTH(8), .PIPE_CUT(2)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a_in(a8), .b_in(b8), .c_in(c8),
`ifdef BK_ADDER_SUB_EN
        .sub_in(sub8),
`endif
        .out_valid(ov8), .out_ready(or8), .sum(s8), .c_out(co8));

    bk_adder_pipe #(.WIDTH(64), .PIPE_CUT(0)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .a_in(a64), .b_in(b64), .c_in(c64),
`ifdef BK_ADDER_SUB_EN
        .sub_in(1'b0),
`endif
        .out_valid(ov64), .out_ready(or64), .sum(s64), .c_out(co64));

    int npass = 0, ntotal = 0;
    logic [64:0] q16[$], q8[$], q64[$];

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic extra(input string tag, input logic [64:0] obs);
        ntotal++;
        assert (0) npass++;
        else $error("FAIL %s: got unexpected result %0h want none", tag, obs);
    endtask

    // Scoreboard: retire on out_valid&out_ready, push on in_valid&in_ready.
    always @(negedge clk) if (rst_n) begin
        if (ov16 && or16) begin
            if (q16.size() == 0) extra("extra16", {co16, s16});
            else chk("res16", 65'({co16, s16}), q16.pop_front());
        end
        if (iv16 && ir16) q16.push_back(65'(a16) + 65'(b16) + 65'(c16));
    end

    always @(negedge clk) if (rst_n) begin
        if (ov8 && or8) begin
            if (q8.size() == 0) extra("extra8", {co8, s8});
            else chk("res8", 65'({co8, s8}), q8.pop_front());
        end
        if (iv8 && ir8)
            q8.push_back(sub8 ? 65'(a8) + 65'(nb8) + 65'd1 : 65'(a8) + 65'(b8) + 65'(c8));
    end

    always @(negedge clk) if (rst_n) begin
        if (ov64 && or64) begin
            if (q64.size() == 0) extra("extra64", {co64, s64});
            else chk("res64", {co64, s64}, q64.pop_front());
        end
        if (iv64 && ir64) q64.push_back(65'(a64) + 65'(b64) + 65'(c64));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait16(inout int n);
        while (!ov16 && n < 20) begin step(); n++; end
    endtask
    task automatic wait8(inout int n);
        while (!ov8 && n < 20) begin step(); n++; end
    endtask
    task automatic wait64(inout int n);
        while (!ov64 && n < 20) begin step(); n++; end
    endtask

    initial begin
        int n;
        logic [16:0] held;

        // Reset state
        step(); step();
        chk("rst_ov16", 65'(ov16), 65'd0);
        chk("rst_sum16", 65'({co16, s16}), 65'd0);
        chk("rst_ready16", 65'(ir16), 65'd1);
        chk("rst_ov8", 65'(ov8), 65'd0);
        chk("rst_ov64", 65'(ov64), 65'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready16", 65'(ir16), 65'd1);

        // W=8: 0xFF + 0x01 wraps to 0 with carry, latency 4, one-cycle valid
        a8 = 8'hFF; b8 = 8'h01; c8 = 0; iv8 = 1;
        step(); iv8 = 0; n = 1;
        wait8(n);
        chk("lat8", 65'(n), 65'd4);
        chk("sum8_wrap", 65'({co8, s8}), 65'h100);
        step();
        chk("ov8_one_cycle", 65'(ov8), 65'd0);

        // W=16 back-to-back, results in order
        a16 = 16'h1234; b16 = 16'h4321; c16 = 0; iv16 = 1;
        step(); a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1;
        step(); iv16 = 0; n = 2;
        wait16(n);
        chk("lat16", 65'(n), 65'd5);
        chk("b2b_first", 65'({co16, s16}), 65'h05555);
        step();
        chk("b2b_second_valid", 65'(ov16), 65'd1);
        chk("b2b_second", 65'({co16, s16}), 65'h1FFFF);
        c16 = 0;
        repeat (3) step();

        // Backpressure: hold 3 cycles with an input waiting
        a16 = 16'h0001; b16 = 16'h0002; iv16 = 1;
        step(); a16 = 16'h8000; b16 = 16'h8000;
        step(); a16 = 16'hABCD; b16 = 16'h1111; c16 = 1;
        step(); iv16 = 0; c16 = 0; n = 3;
        wait16(n);
        or16 = 0;
        held = {co16, s16};
        chk("hold_first_val", 65'(held), 65'h00003);
        a16 = 16'h7777; b16 = 16'h0001; iv16 = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_valid", 65'(ov16), 65'd1);
            chk("hold_data", 65'({co16, s16}), 65'(held));
            chk("hold_ready", 65'(ir16), 65'd0);
        end
        or16 = 1;
        step(); iv16 = 0;
        n = 0;
        while (q16.size() > 0 && n < 30) begin step(); n++; end
        chk("hold_drained", 65'(q16.size()), 65'd0);
        repeat (4) step();

        // Reset with results in flight
        or16 = 0;
        a16 = 16'h1111; b16 = 16'h2222; iv16 = 1;
        step(); a16 = 16'h3333;
        step(); a16 = 16'h4444;
        step(); iv16 = 0; n = 3;
        wait16(n);
        chk("pre_rst_valid", 65'(ov16), 65'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ov16", 65'(ov16), 65'd0);
        chk("rst_mid_sum16", 65'({co16, s16}), 65'd0);
        q16.delete(); q8.delete(); q64.delete();
        step();
        rst_n = 1'b1; or16 = 1;
        repeat (10) step();
        chk("no_stale16", 65'(ov16), 65'd0);
        a16 = 16'h00FF; b16 = 16'h0F01; iv16 = 1;
        step(); iv16 = 0; n = 1;
        wait16(n);
        chk("post_rst_lat16", 65'(n), 65'd5);
        chk("post_rst_sum16", 65'({co16, s16}), 65'h01000);
        repeat (3) step();

`ifdef BK_ADDER_SUB_EN
        // Subtract mode: c_in ignored, c_out=1 means no borrow
        sub8 = 1; c8 = 1;
        a8 = 8'h05; b8 = 8'h07; iv8 = 1;
        step(); a8 = 8'h07; b8 = 8'h05;
        step(); iv8 = 0; n = 2;
        wait8(n);
        chk("sub_borrow", 65'({co8, s8}), 65'h0FE);
        step();
        chk("sub_noborrow", 65'({co8, s8}), 65'h102);
        step(); sub8 = 0; c8 = 0;
`endif

        // W=64, PIPE_CUT=0: latency 2 then random traffic with backpressure
        a64 = '1; b64 = 64'd1; c64 = 1; iv64 = 1;
        step(); iv64 = 0; n = 1;
        wait64(n);
        chk("lat64", 65'(n), 65'd2);
        chk("sum64_wrap", {co64, s64}, {1'b1, 64'd1});
        step();
        for (int k = 0; k < 10000; k++) begin
            iv64 = ($urandom_range(0, 3) != 0);
            or64 = ($urandom_range(0, 3) != 0);
            a64  = {$urandom, $urandom};
            b64  = {$urandom, $urandom};
            c64  = 1'($urandom_range(0, 1));
            step();
        end
        iv64 = 0; or64 = 1;
        n = 0;
        while (q64.size() > 0 && n < 30) begin step(); n++; end
        chk("drain64", 65'(q64.size()), 65'd0);
        chk("drain8", 65'(q8.size()), 65'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
